// File: rtl/mips_reg_file_sb_pkg.sv
// Shared defaults and types for the pipelined MIPS register file with hazard scoreboard.
package mips_rf_pkg;
  localparam int          DATA_W   = 32;
  localparam int          NUM_REGS = 32;
  localparam int          ADDR_W   = $clog2(NUM_REGS);
  localparam int          SP_INDEX = 29;
  localparam logic [31:0] SP_INIT  = 32'h0000_1FFF;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/mips_reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, issue reservation, hazard outputs.
interface mips_reg_file_sb_if #(
  parameter int DATA_W   = mips_rf_pkg::DATA_W,
  parameter int NUM_REGS = mips_rf_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic [ADDR_W-1:0]   Read_Reg_1, Read_Reg_2;
  logic [DATA_W-1:0]   Read_Data_1, Read_Data_2;
  logic [ADDR_W-1:0]   Write_Reg;
  logic [DATA_W-1:0]   Write_Data;
  logic                Reg_Write;
  logic                Issue_Valid;
  logic [ADDR_W-1:0]   Issue_Reg;
  logic                Use_1, Use_2;
  logic                Stall;
  logic [NUM_REGS-1:0] Pending;

  modport master (
    output Read_Reg_1, Read_Reg_2, Write_Reg, Write_Data, Reg_Write,
           Issue_Valid, Issue_Reg, Use_1, Use_2,
    input  Read_Data_1, Read_Data_2, Stall, Pending
  );

  modport slave (
    input  Read_Reg_1, Read_Reg_2, Write_Reg, Write_Data, Reg_Write,
           Issue_Valid, Issue_Reg, Use_1, Use_2,
    output Read_Data_1, Read_Data_2, Stall, Pending
  );
endinterface

// File: rtl/mips_reg_file_sb_scoreboard.sv
// In-flight write tracker: per-register pending bits and RAW stall generation.
// REG_FILE_BYPASS_EN lets a same-cycle writeback cancel the stall on its operand.
module mips_rf_scoreboard #(
  parameter int NUM_REGS = mips_rf_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  input  logic                reg_write,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic                use_1,
  input  logic                use_2,
  input  logic [ADDR_W-1:0]   rd_reg_1,
  input  logic [ADDR_W-1:0]   rd_reg_2,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                clr1, clr2;

  // Set is applied after clear so a re-issue on the writeback edge stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (reg_write && write_reg != '0)
      pend_d[write_reg] = 1'b0;
    if (issue_valid && issue_reg != '0)
      pend_d[issue_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) pend_q <= '0;
    else          pend_q <= pend_d;

`ifdef REG_FILE_BYPASS_EN
  assign clr1 = reg_write && (write_reg == rd_reg_1) && (rd_reg_1 != '0);
  assign clr2 = reg_write && (write_reg == rd_reg_2) && (rd_reg_2 != '0);
`else
  assign clr1 = 1'b0;
  assign clr2 = 1'b0;
`endif

  assign stall   = (use_1 && pend_q[rd_reg_1] && !clr1) ||
                   (use_2 && pend_q[rd_reg_2] && !clr2);
  assign pending = pend_q;
endmodule

// File: rtl/mips_reg_file_sb.sv
// Pipelined MIPS register file: 2 combinational reads, 1 synchronous write, r0 = 0, SP preset, RAW scoreboard.
// REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module mips_reg_file_sb
  import mips_rf_pkg::*;
#(
  parameter int               DATA_W   = mips_rf_pkg::DATA_W,
  parameter int               NUM_REGS = mips_rf_pkg::NUM_REGS,
  parameter int               ADDR_W   = $clog2(NUM_REGS),
  parameter int               SP_INDEX = mips_rf_pkg::SP_INDEX,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(mips_rf_pkg::SP_INIT)
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  mips_reg_file_sb_if.slave    bus
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                            wr_en;

  assign wr_en = bus.Reg_Write && (bus.Write_Reg != ZERO_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wr_en)
      regs_d[bus.Write_Reg] = bus.Write_Data;
  end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      regs_q           <= '0;
      regs_q[SP_INDEX] <= SP_INIT;
    end else begin
      regs_q <= regs_d;
    end

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0]               idx,
    input logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input logic                            we,
    input logic [ADDR_W-1:0]               widx,
    input logic [DATA_W-1:0]               wdata
  );
    logic [DATA_W-1:0] r;
    r = regs[idx];
`ifdef REG_FILE_BYPASS_EN
    if (we && widx == idx) r = wdata;
`else
    if (we && widx == idx && wdata != wdata) r = '0;  // keeps the port list build-independent
`endif
    if (idx == ZERO_IDX) r = '0;
    return r;
  endfunction

  assign bus.Read_Data_1 = rd_mux(bus.Read_Reg_1, regs_q, wr_en, bus.Write_Reg, bus.Write_Data);
  assign bus.Read_Data_2 = rd_mux(bus.Read_Reg_2, regs_q, wr_en, bus.Write_Reg, bus.Write_Data);

  mips_rf_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .issue_valid (bus.Issue_Valid),
    .issue_reg   (bus.Issue_Reg),
    .reg_write   (bus.Reg_Write),
    .write_reg   (bus.Write_Reg),
    .use_1       (bus.Use_1),
    .use_2       (bus.Use_2),
    .rd_reg_1    (bus.Read_Reg_1),
    .rd_reg_2    (bus.Read_Reg_2),
    .pending     (bus.Pending),
    .stall       (bus.Stall)
  );
endmodule
